// File: rtl/multich_selftrigger_discriminator_if.sv
// -----------------------------------------------------------------------------
// multich_selftrigger_discriminator_if
// Configuration bus for the multichannel self-trigger discriminator.
//   cfg_we     : write strobe
//   cfg_rd     : read request (ignored when cfg_we is also high)
//   cfg_ch     : channel address
//   cfg_reg    : 0=threshold, 1=hysteresis, 2=deadtime, 3=trigger count
//   cfg_wdata  : write data
//   cfg_rdata  : registered read data
//   cfg_rvalid : read data valid, one cycle after the request
// Modports: master (bus driver), slave (discriminator).
// -----------------------------------------------------------------------------
interface multich_selftrigger_discriminator_if #(
   parameter int ADDR_W = 6
) ();
   logic              cfg_we;
   logic              cfg_rd;
   logic [ADDR_W-1:0] cfg_ch;
   logic [1:0]        cfg_reg;
   logic [31:0]       cfg_wdata;
   logic [31:0]       cfg_rdata;
   logic              cfg_rvalid;

   modport master (
      output cfg_we, cfg_rd, cfg_ch, cfg_reg, cfg_wdata,
      input  cfg_rdata, cfg_rvalid
   );

   modport slave (
      input  cfg_we, cfg_rd, cfg_ch, cfg_reg, cfg_wdata,
      output cfg_rdata, cfg_rvalid
   );
endinterface

// File: rtl/multich_selftrigger_discriminator.sv
// -----------------------------------------------------------------------------
// multich_selftrigger_discriminator
// Per-channel threshold discriminator with hysteresis re-arming and
// sample-counted deadtime, for the filtered AFE sample bus.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   enable   : discriminator enable; low forces every channel ARMED
//   x        : NCH packed signed samples, channel c at [c*W +: W]
//   x_valid  : qualifies x; channel state only advances on valid samples
//   cfg      : configuration bus (slave modport)
//   trigger  : registered one-cycle trigger pulse per channel
// Optional feature macro: TRIG_COUNTER_EN builds a 16-bit saturating trigger
// counter per channel, read and cleared through register 3. Without it
// register 3 reads 0 and writes to it are dropped.
// -----------------------------------------------------------------------------
module multich_selftrigger_discriminator #(
   parameter int NCH    = 40,
   parameter int W      = 16,
   parameter int DT_W   = 10,
   parameter int ADDR_W = 6
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic [NCH*W-1:0]                     x,
   input  logic                                 x_valid,
   multich_selftrigger_discriminator_if.slave   cfg,
   output logic [NCH-1:0]                       trigger
);

   typedef enum logic [1:0] {
      ST_ARMED = 2'd0,
      ST_DEAD  = 2'd1,
      ST_REARM = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] NCH_L = (ADDR_W+1)'(NCH);

   // configuration registers
   logic signed [31:0] thr_r  [NCH];
   logic [W-1:0]       hyst_r [NCH];
   logic [DT_W-1:0]    dt_r   [NCH];

   // per-channel discriminator state
   state_t             state_r   [NCH];
   state_t             state_nxt [NCH];
   logic [DT_W-1:0]    cnt_r     [NCH];
   logic [DT_W-1:0]    cnt_nxt   [NCH];
   logic [NCH-1:0]     trig_nxt;
   logic [NCH-1:0]     trig_r;

   // 33-bit signed views so that thr - hyst can never overflow
   logic signed [32:0] samp_s  [NCH];
   logic signed [32:0] thr33_s [NCH];
   logic signed [32:0] rearm_s [NCH];

   logic               ch_ok_s;
   logic [31:0]        rd_val_s;
   logic [31:0]        rdata_r;
   logic               rvalid_r;

   assign ch_ok_s        = ({1'b0, cfg.cfg_ch} < NCH_L);
   assign trigger        = trig_r;
   assign cfg.cfg_rdata  = rdata_r;
   assign cfg.cfg_rvalid = rvalid_r;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign samp_s[g]  = {{(33-W){x[g*W+W-1]}}, x[g*W +: W]};
      assign thr33_s[g] = {thr_r[g][31], thr_r[g]};
      assign rearm_s[g] = thr33_s[g] - {{(33-W){1'b0}}, hyst_r[g]};
   end

   // Configuration register writes; out-of-range channels are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            thr_r[c]  <= 32'sd99999;
            hyst_r[c] <= '0;
            dt_r[c]   <= '0;
         end
      end else if (cfg.cfg_we && ch_ok_s) begin
         case (cfg.cfg_reg)
            2'd0:    thr_r[cfg.cfg_ch]  <= cfg.cfg_wdata;
            2'd1:    hyst_r[cfg.cfg_ch] <= cfg.cfg_wdata[W-1:0];
            2'd2:    dt_r[cfg.cfg_ch]   <= cfg.cfg_wdata[DT_W-1:0];
            default: ;
         endcase
      end
   end

   // Next-state logic of every channel discriminator
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         state_nxt[c] = state_r[c];
         cnt_nxt[c]   = cnt_r[c];
         trig_nxt[c]  = 1'b0;
         if (!enable) begin
            state_nxt[c] = ST_ARMED;
            cnt_nxt[c]   = '0;
         end else if (x_valid) begin
            case (state_r[c])
               ST_ARMED: begin
                  if (samp_s[c] > thr33_s[c]) begin
                     trig_nxt[c] = 1'b1;
                     // zero deadtime skips DEAD entirely
                     if (dt_r[c] == '0) begin
                        state_nxt[c] = ST_REARM;
                        cnt_nxt[c]   = '0;
                     end else begin
                        state_nxt[c] = ST_DEAD;
                        cnt_nxt[c]   = dt_r[c];
                     end
                  end else begin
                     state_nxt[c] = ST_ARMED;
                  end
               end
               ST_DEAD: begin
                  // cnt counts the dead samples still to come, this one included
                  if (cnt_r[c] == DT_W'(1)) begin
                     state_nxt[c] = ST_REARM;
                     cnt_nxt[c]   = '0;
                  end else begin
                     cnt_nxt[c]   = cnt_r[c] - DT_W'(1);
                  end
               end
               ST_REARM: begin
                  if (samp_s[c] <= rearm_s[c]) begin
                     state_nxt[c] = ST_ARMED;
                  end else begin
                     state_nxt[c] = ST_REARM;
                  end
               end
               default: begin
                  state_nxt[c] = ST_ARMED;
                  cnt_nxt[c]   = '0;
               end
            endcase
         end else begin
            state_nxt[c] = state_r[c];
         end
      end
   end

   // Discriminator state, deadtime counters and registered trigger pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            state_r[c] <= ST_ARMED;
            cnt_r[c]   <= '0;
         end
         trig_r <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            state_r[c] <= state_nxt[c];
            cnt_r[c]   <= cnt_nxt[c];
         end
         trig_r <= trig_nxt;
      end
   end

`ifdef TRIG_COUNTER_EN
   logic [15:0] tcnt_r [NCH];

   // Saturating trigger counters; a clear beats a coincident trigger
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            tcnt_r[c] <= 16'd0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (cfg.cfg_we && ch_ok_s && (cfg.cfg_reg == 2'd3) &&
                (cfg.cfg_ch == ADDR_W'(c))) begin
               tcnt_r[c] <= 16'd0;
            end else if (trig_nxt[c] && (tcnt_r[c] != 16'hFFFF)) begin
               tcnt_r[c] <= tcnt_r[c] + 16'd1;
            end
         end
      end
   end
`endif

   // Read-back multiplexer
   always_comb begin
      rd_val_s = 32'd0;
      if (ch_ok_s) begin
         case (cfg.cfg_reg)
            2'd0:    rd_val_s = thr_r[cfg.cfg_ch];
            2'd1:    rd_val_s = {{(32-W){1'b0}}, hyst_r[cfg.cfg_ch]};
            2'd2:    rd_val_s = {{(32-DT_W){1'b0}}, dt_r[cfg.cfg_ch]};
`ifdef TRIG_COUNTER_EN
            2'd3:    rd_val_s = {16'd0, tcnt_r[cfg.cfg_ch]};
`else
            2'd3:    rd_val_s = 32'd0;
`endif
            default: rd_val_s = 32'd0;
         endcase
      end else begin
         rd_val_s = 32'd0;
      end
   end

   // Registered read port; a simultaneous write suppresses the read
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_r  <= 32'd0;
         rvalid_r <= 1'b0;
      end else if (cfg.cfg_rd && !cfg.cfg_we) begin
         rdata_r  <= rd_val_s;
         rvalid_r <= 1'b1;
      end else begin
         rvalid_r <= 1'b0;
      end
   end

endmodule

// File: doc/multich_selftrigger_discriminator.md
# multich_selftrigger_discriminator

Parametrised multichannel self-trigger discriminator for the filtered AFE sample bus. Each channel compares its filtered sample against a programmable signed threshold and issues a one-cycle trigger pulse. A per-channel state machine adds hysteresis re-arming and sample-counted deadtime. A single-port configuration bus holds the per-channel threshold, hysteresis and deadtime registers, with a registered read-back path. The block sits after the pedestal-recovery/moving-mean filters and feeds the self-trigger readout logic.

## Interface
- NCH, 40, number of channels
- W, 16, sample width (signed two's complement)
- DT_W, 10, deadtime counter width
- ADDR_W, 6, channel address width (2^ADDR_W >= NCH)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- enable  in  1  discriminator enable
- x  in  NCH*W  samples; channel c at bits [c*W+W-1 : c*W]
- x_valid  in  1  qualifies x; state advances only on x_valid cycles
- cfg_we  in  1  write strobe
- cfg_rd  in  1  read request
- cfg_ch  in  ADDR_W  channel address
- cfg_reg  in  2  0=threshold, 1=hysteresis, 2=deadtime, 3=trigger count
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data
- cfg_rvalid  out  1  read data valid
- trigger  out  NCH  per-channel trigger pulses

## Operation
- Registers per channel: thr signed 32 (reset 99999, unreachable by a W=16 sample), hyst unsigned W (reset 0), dt unsigned DT_W (reset 0).
- Writes: on cfg_we, update reg cfg_reg of channel cfg_ch from cfg_wdata LSBs. Writes with cfg_ch >= NCH are ignored. A write to reg 3 clears that channel's counter.
- Reads: on cfg_rd with cfg_we low, cfg_rdata and cfg_rvalid are valid on the next cycle. Unsigned fields are zero-extended. cfg_ch >= NCH returns 0.
- Read with cfg_we in the same cycle: the write wins and no read occurs; cfg_rvalid stays 0.
- Comparison arithmetic: sample sign-extended to 33 bits; thr sign-extended to 33 bits. Re-arm level = thr − hyst, computed in 33 bits, so no overflow.
- Per-channel FSM, evaluated on x_valid:
  - ARMED: if x > thr, pulse trigger and go to DEAD with cnt=dt. If dt == 0, go straight to REARM.
  - DEAD: decrement cnt each valid sample; at cnt == 1, go to REARM. The total dead samples equal dt.
  - REARM: if x <= thr − hyst, go to ARMED. No trigger is possible in this state.
- enable low: all FSMs are forced to ARMED, trigger is held at 0, and configuration access still works.
- Threshold and hysteresis changes apply from the next valid sample. Changing dt does not alter a running cnt.

## Timing
- trigger is registered: it is high exactly one clk cycle, the cycle after the clk edge sampling the crossing x_valid sample.
- Latency from crossing sample to trigger = 1 cycle. Config read latency = 1 cycle.
- A config write takes effect on comparisons starting with the next clock.
- Reset values: trigger=0, cfg_rdata=0, cfg_rvalid=0, all FSMs ARMED, counters 0.
- Reset mid-DEAD returns the channel to ARMED and restores register defaults.
- Multiple channels may trigger in the same cycle; they are independent.
- x_valid low: FSMs and cnt hold, and no trigger is issued.

## Configuration
- TRIG_COUNTER_EN:
  - Defined: each channel has a 16-bit trigger counter. It increments once per trigger pulse and saturates at 65535. Reg 3 reads it; a write to reg 3 clears it. A trigger and a clear in the same cycle give 0.
  - Undefined: no counters are built. Reg 3 reads 0 and writes to it are ignored.

## Test plan
- Reset, then read ch5 thr -> cfg_rvalid 1 cycle later, cfg_rdata=99999. A sample of x=32767 produces no trigger.
- ch0: thr=1000, hyst=100, dt=4. Sample sequence 900, 1001, 1200×6, 950, 899, 1001 (all x_valid) -> trigger pulses at the 1001 and at the final 1001 only, with no pulse during the DEAD or REARM samples.
- ch3: thr=−50, dt=0, hyst=0. Samples −60, −49, −51, −49 -> two pulses, each one cycle after the −49 sample.
- Assert enable=0 during ch0 DEAD -> trigger stays 0. After enable=1, a sample >thr triggers immediately.
- Write cfg_ch=45 thr=0 -> no effect; read cfg_ch=45 returns 0. Simultaneous cfg_we and cfg_rd -> cfg_rvalid stays 0.
- With TRIG_COUNTER_EN defined: 3 triggers on ch7 -> reg 3 reads 3. Write reg 3 -> reads 0. Without the macro, reg 3 reads 0 after triggers.
